// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one external combinational adder among NUM_REQ requesters.
// Optional ADDER_SAT_EN: saturate rsp_data on signed overflow instead of wrapping.
module adder_share_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_ovf,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_ovf,
  input  logic                     rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   own_q, own_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_ovf_q, rsp_ovf_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_sub;
  logic [WIDTH-1:0]  gnt_a;
  logic [WIDTH-1:0]  gnt_b;
  logic              grant_en;
  logic [31:0]       scan_idx;
  logic [WIDTH-1:0]  res_data;

  // Scan from the pointer so simultaneous requests are ordered by rotation only.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_sub   = 1'b0;
    gnt_a     = '0;
    gnt_b     = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!gnt_found && req_valid[ID_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(scan_idx);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_sub = req_sub[i];
        gnt_a   = req_a[i*WIDTH +: WIDTH];
        gnt_b   = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign grant_en  = rst_n && gnt_found &&
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
`ifdef ADDER_SAT_EN
    if (add_ovf) begin
      res_data = add_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_data = add_s;
    end
`else
    res_data = add_s;
`endif
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    case (state_q)
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = own_q;
        rsp_data_d  = res_data;
        rsp_ovf_d   = add_ovf;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant from IDLE or from an accepted RESP loads the adder operands identically.
    if (grant_en) begin
      own_d     = gnt_id;
      add_a_d   = gnt_a;
      add_b_d   = gnt_sub ? ~gnt_b : gnt_b;
      add_cin_d = gnt_sub;
      ptr_d     = ID_W'((32'(gnt_id) + 32'd1) % NUM_REQ);
      state_d   = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: transaction-level model plus directed vectors.
module tb_adder_share_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_sub = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    add_a, add_b, add_s;
  logic            add_cin, add_ovf;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_ovf;
  logic            rsp_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_ovf(add_ovf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready)
  );

  // Stand-in for the shared external adder.
  logic [W:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_s    = sum_full[W-1:0];
  assign add_ovf  = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one op in flight, one response held, rotation pointer.
  int          m_ptr = 0;
  bit          m_inflight = 1'b0;
  bit          m_held = 1'b0;
  int          p_id;
  logic [W-1:0] p_a, p_bx, p_data;
  bit          p_cin, p_ovf;
  int          h_id;
  logic [W-1:0] h_data;
  bit          h_ovf;

  function automatic int pick();
    if (!rst_n) return -1;
    if (m_inflight || (m_held && !rsp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void arith(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] data, output bit ovf);
    int sa, sb, r;
    sa   = $signed(a);
    sb   = $signed(b);
    r    = sub ? sa - sb : sa + sb;
    ovf  = (r > 32767) || (r < -32768);
    data = r[W-1:0];
`ifdef ADDER_SAT_EN
    if (ovf) data = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  always @(posedge clk) begin
    int g;
    logic [W-1:0] a, b;
    bit s;
    g = pick();
    if (!rst_n) begin
      m_ptr = 0; m_inflight = 1'b0; m_held = 1'b0;
    end else begin
      if (m_held && rsp_ready) m_held = 1'b0;
      if (m_inflight) begin
        m_held = 1'b1; h_id = p_id; h_data = p_data; h_ovf = p_ovf; m_inflight = 1'b0;
      end
      if (g >= 0) begin
        a = req_a[g*W +: W];
        b = req_b[g*W +: W];
        s = req_sub[g];
        p_id = g; p_a = a; p_bx = s ? ~b : b; p_cin = s;
        arith(s, a, b, p_data, p_ovf);
        m_inflight = 1'b1;
        m_ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (chk_en) begin
      g  = pick();
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_held));
      if (m_held) begin
        chk("rsp_id", 32'(rsp_id), 32'(h_id));
        chk("rsp_data", 32'(rsp_data), 32'(h_data));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(h_ovf));
      end
      if (m_inflight) begin
        chk("add_a", 32'(add_a), 32'(p_a));
        chk("add_b", 32'(add_b), 32'(p_bx));
        chk("add_cin", 32'(add_cin), 32'(p_cin));
      end
    end
  end

  task automatic set_req(input int i, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
    req_sub[i] = sub;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (req_ready[i]) seen = 1'b1;
    end
    chk("grant_seen", 32'(seen), 32'd1);
  endtask

  task automatic op(input int i, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] exp_data, input bit exp_ovf);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    set_req(i, sub, a, b);
    wait_grant(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_a[i*W +: W] = 16'hDEAD;
    req_b[i*W +: W] = 16'hBEEF;
    req_sub[i] = ~sub;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    chk("lit_latency", 32'(n), 32'd2);
    chk("lit_id", 32'(rsp_id), 32'(i));
    chk("lit_data", 32'(rsp_data), 32'(exp_data));
    chk("lit_ovf", 32'(rsp_ovf), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int gq[$];
    int tq[$];
    int hold_id;
    logic [W-1:0] hold_data;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {rsp_valid, rsp_id, rsp_ovf, add_cin, req_ready}, 32'd0);
    chk("rst_data", {add_a, add_b}, 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    op(0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    op(1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
`ifdef ADDER_SAT_EN
    op(2, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    op(3, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1);
    op(0, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1);
`else
    op(2, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    op(3, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    op(0, 1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b1);
`endif

    // Backpressure, with requester 2 dropping out before it can be granted
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 16'h1234, 16'h1111);
    wait_grant(1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_data", 32'(rsp_data), 32'h2345);
    hold_id = 32'(rsp_id);
    hold_data = rsp_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) set_req(2, 1'b0, 16'h0001, 16'h0001);
      if (c == 2) req_valid[2] = 1'b0;
      if (c == 3) set_req(3, 1'b1, 16'h0010, 16'h0001);
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
      chk("bp_hold_data", 32'(rsp_data), 32'(hold_data));
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during EXEC discards the operation and clears the pointer
    #1 set_req(2, 1'b0, 16'h0100, 16'h0200);
    wait_grant(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid[2] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_exec_no_rsp", 32'(seen), 32'd0);

    // All requesters valid, consumer always ready
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(i + 1), 16'(10 * i));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          gq.push_back(i);
          tq.push_back(c);
        end
      end
    end
    @(posedge clk); #1 req_valid = '0;
    chk("rr_count", 32'(gq.size()), 32'd6);
    if (gq.size() >= 5) begin
      chk("rr_g0", 32'(gq[0]), 32'd0);
      chk("rr_g1", 32'(gq[1]), 32'd1);
      chk("rr_g2", 32'(gq[2]), 32'd2);
      chk("rr_g3", 32'(gq[3]), 32'd3);
      chk("rr_g4", 32'(gq[4]), 32'd0);
      for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(tq[k] - tq[k-1]), 32'd2);
    end
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
